// File: rtl/ram_burst_reader.sv
// ram_burst_reader: read-side burst master for the dual-clock block RAM.
// Fetches `length` consecutive words from `base_addr` (wrapping) through the
// RAM read port and presents them as a valid/ready stream with a last flag.
// A 4-entry prefetch FIFO absorbs downstream backpressure.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; length==0 start only pulses done
// RUN    | issuing reads and draining the FIFO until last handshake/abort

module ram_burst_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   issue_left_q;
    logic                  rd_last_q;
    logic                  p2_valid_q;
    logic                  p2_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [4];
    logic                  fifo_last_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            fifo_count_q;

    logic                  len_nz;
    logic                  issue_go;
    logic                  flush;
    logic                  pop;
    logic                  fifo_wr;
    logic [2:0]            occupancy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: leave RUN on abort or on the handshake of the last word.
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (start && len_nz) state_d = S_RUN;
        end else begin
            if (abort)                          state_d = S_IDLE;
            else if (m_valid && m_ready && m_last) state_d = S_IDLE;
        end
    end

    // Outputs and control strobes. Occupancy uses registered counts only, so a
    // pop in this cycle does not free a slot for an issue in this cycle.
    always_comb begin
        busy      = (state_q == S_RUN);
        m_valid   = (fifo_count_q != 3'd0);
        m_data    = fifo_data_q[rd_ptr_q];
        m_last    = fifo_last_q[rd_ptr_q];
        pop       = m_valid && m_ready;
        flush     = (state_q == S_RUN) && abort;
        fifo_wr   = p2_valid_q && !flush;
        len_nz    = (length != '0);
        occupancy = fifo_count_q + {2'b00, ram_rd_en} + {2'b00, p2_valid_q};
        issue_go  = 1'b0;
        if (state_q == S_IDLE) begin
            issue_go = start && len_nz;
        end else begin
            issue_go = !abort && (issue_left_q != '0) && (occupancy < 3'd4);
        end
    end

    // Read issue: registered enable/address, remaining-word down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rd_en    <= 1'b0;
            ram_rd_addr  <= '0;
            issue_left_q <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            ram_rd_en <= issue_go;
            if (issue_go) begin
                if (state_q == S_IDLE) begin
                    ram_rd_addr  <= base_addr;
                    issue_left_q <= length - LEN_ONE;
                    rd_last_q    <= (length == LEN_ONE);
                end else begin
                    ram_rd_addr  <= ram_rd_addr + ADDR_ONE;
                    issue_left_q <= issue_left_q - LEN_ONE;
                    rd_last_q    <= (issue_left_q == LEN_ONE);
                end
            end
        end
    end

    // Second capture stage: flags the cycle in which ram_rd_data is fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_valid_q <= 1'b0;
            p2_last_q  <= 1'b0;
        end else begin
            p2_valid_q <= ram_rd_en && !flush;
            p2_last_q  <= rd_last_q;
        end
    end

    // Prefetch FIFO; abort drops everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
        end else if (flush) begin
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
        end else begin
            if (fifo_wr) begin
                fifo_data_q[wr_ptr_q] <= ram_rd_data;
                fifo_last_q[wr_ptr_q] <= p2_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (fifo_wr && !pop)      fifo_count_q <= fifo_count_q + 3'd1;
            else if (!fifo_wr && pop) fifo_count_q <= fifo_count_q - 3'd1;
        end
    end

    // Completion pulse: normal end of burst, or zero-length start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= ((state_q == S_IDLE) && start && !len_nz) ||
                            ((state_q == S_RUN) && !abort && pop && m_last);
    end

    // The issue rule keeps occupancy at or below four entries.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && !pop && (fifo_count_q == 3'd4)));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural registered-read RAM
// preloaded with RAM[i] = i.

module tb_ram_burst_reader;
    localparam int AW = 10;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] ram_mem [0:1023];

    int errors = 0;
    int checks = 0;

    int            cyc;
    int            ready_mode;
    int            iss_addr[$];
    int            iss_cyc[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int            got_cyc[$];
    int            done_cnt;
    int            done_cyc;
    int            busy_cnt;
    int            overlap;
    int            first_valid;

    always #5 clk = ~clk;

    // Registered-read RAM: output holds its old value when not enabled.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    end

    ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    // Advance n cycles, logging observations at each falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (ram_rd_en) begin
                iss_addr.push_back(int'(ram_rd_addr));
                iss_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done && busy) overlap++;
            if (busy) busy_cnt++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
        end
    endtask

    // Called at a falling edge: clears logs and presents a start command.
    task automatic start_burst(input int base, input int len, input int mode);
        iss_addr.delete(); iss_cyc.delete();
        got_data.delete(); got_last.delete(); got_cyc.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; overlap = 0; first_valid = -1;
        cyc = 0;
        ready_mode = mode;
        m_ready   = (mode == 1);
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        start     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", ram_rd_en); end
        checks++; if (ram_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", ram_rd_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_burst(5, 4, 1);
        run_cycles(12);
        checks++;
        if (iss_addr.size() != 4) begin
            errors++; $display("FAIL basic_issue_count: got %0d want 4", iss_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (iss_addr[k] != 5 + k || iss_cyc[k] != 1 + k) begin
                    errors++; $display("FAIL basic_issue[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d",
                                       k, iss_addr[k], iss_cyc[k], 5 + k, 1 + k);
                end
            end
        end
        checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_first_valid: got %0d want 3", first_valid); end
        checks++;
        if (got_data.size() != 4) begin
            errors++; $display("FAIL basic_word_count: got %0d want 4", got_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_data[k] !== DW'(5 + k) || got_last[k] !== (k == 3) || got_cyc[k] != 3 + k) begin
                    errors++; $display("FAIL basic_word[%0d]: got data %0d last %b cyc %0d want data %0d last %b cyc %0d",
                                       k, got_data[k], got_last[k], got_cyc[k], 5 + k, (k == 3), 3 + k);
                end
            end
            checks++;
            if (done_cyc != got_cyc[3] + 1) begin
                errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, got_cyc[3] + 1);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL basic_done_busy: got %0d want 0", overlap); end
    endtask

    task automatic test_wrap();
        start_burst(1022, 4, 1);
        run_cycles(12);
        checks++;
        if (iss_addr.size() != 4 || got_data.size() != 4) begin
            errors++; $display("FAIL wrap_count: got issues %0d words %0d want 4 4", iss_addr.size(), got_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (iss_addr[k] != (1022 + k) % 1024 || got_data[k] !== DW'((1022 + k) % 1024)) begin
                    errors++; $display("FAIL wrap_word[%0d]: got addr %0d data %0d want %0d",
                                       k, iss_addr[k], got_data[k], (1022 + k) % 1024);
                end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        start_burst(20, 16, 0);
        run_cycles(10);
        checks++; if (iss_addr.size() != 4) begin errors++; $display("FAIL stall_issue_count: got %0d want 4", iss_addr.size()); end
        checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en: got %b want 0", ram_rd_en); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== DW'(20) || m_last !== 1'b0) begin
            errors++; $display("FAIL stall_head: got valid %b data %0d last %b want 1 20 0", m_valid, m_data, m_last);
        end
        ready_mode = 2;
        run_cycles(150);
        checks++;
        if (got_data.size() != 16) begin
            errors++; $display("FAIL stall_word_count: got %0d want 16", got_data.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (got_data[k] !== DW'(20 + k) || got_last[k] !== (k == 15)) begin
                    errors++; $display("FAIL stall_word[%0d]: got data %0d last %b want %0d %b",
                                       k, got_data[k], got_last[k], 20 + k, (k == 15));
                end
            end
        end
        checks++; if (iss_addr.size() != 16) begin errors++; $display("FAIL stall_total_issues: got %0d want 16", iss_addr.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL stall_done_busy: got %0d want 0", overlap); end
    endtask

    task automatic test_zero_length();
        start_burst(7, 0, 1);
        run_cycles(6);
        checks++; if (iss_addr.size() != 0) begin errors++; $display("FAIL zero_issues: got %0d want 0", iss_addr.size()); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d cycles want 0", busy_cnt); end
        checks++;
        if (done_cnt != 1 || done_cyc != 1) begin
            errors++; $display("FAIL zero_done: got count %0d cyc %0d want 1 1", done_cnt, done_cyc);
        end
    endtask

    task automatic test_abort();
        int n_iss;
        start_burst(50, 16, 0);
        run_cycles(5);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b want 1", m_valid); end
        n_iss = iss_addr.size();
        abort = 1'b1;
        run_cycles(1);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || ram_rd_en !== 1'b0) begin
            errors++; $display("FAIL abort_flush: got valid %b busy %b rd_en %b want 0 0 0", m_valid, busy, ram_rd_en);
        end
        ready_mode = 1;
        run_cycles(6);
        checks++;
        if (got_data.size() != 0 || done_cnt != 0 || iss_addr.size() != n_iss) begin
            errors++; $display("FAIL abort_quiet: got words %0d done %0d issues %0d want 0 0 %0d",
                               got_data.size(), done_cnt, iss_addr.size(), n_iss);
        end
        start_burst(100, 2, 1);
        run_cycles(10);
        checks++;
        if (got_data.size() != 2) begin
            errors++; $display("FAIL abort_next_count: got %0d want 2", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== DW'(100) || got_data[1] !== DW'(101) || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
                errors++; $display("FAIL abort_next_words: got %0d/%b %0d/%b want 100/0 101/1",
                                   got_data[0], got_last[0], got_data[1], got_last[1]);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_next_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_midburst();
        start_burst(200, 16, 1);
        run_cycles(5);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_rd_en !== 1'b0 || ram_rd_addr !== '0 ||
            m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
            errors++; $display("FAIL async_reset_outputs: got busy %b done %b rd_en %b addr %0d valid %b data %0d last %b want all 0",
                               busy, done, ram_rd_en, ram_rd_addr, m_valid, m_data, m_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(3);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset_no_done: got done %0d busy %b want 0 0", done_cnt, busy);
        end
        start_burst(300, 3, 1);
        run_cycles(2);
        start     = 1'b1;
        base_addr = '0;
        length    = 11'd9;
        run_cycles(15);
        checks++;
        if (got_data.size() != 3 || iss_addr.size() != 3) begin
            errors++; $display("FAIL restart_count: got words %0d issues %0d want 3 3", got_data.size(), iss_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got_data[k] !== DW'(300 + k) || got_last[k] !== (k == 2)) begin
                    errors++; $display("FAIL restart_word[%0d]: got %0d last %b want %0d %b",
                                       k, got_data[k], got_last[k], 300 + k, (k == 2));
                end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = DW'(i);
        ram_rd_data = '0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        base_addr = '0; length = '0; ready_mode = 1;
        cyc = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; overlap = 0; first_valid = -1;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_length();
        test_abort();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
